// File: rtl/peri_mems_mic_pkg.sv
// rtl/peri_mems_mic_pkg.sv - register map, bit positions and FIFO entry type for the PDM mic array
package peri_mems_mic_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_N_LSB      = 1;
    localparam int CTRL_N_MSB      = 3;
    localparam int CTRL_STEREO_BIT = 4;
    localparam int STAT_OVF_BIT    = 7;
    localparam int STAT_TAG_BIT    = 6;

    localparam logic [7:0] CTRL_RESET = 8'h0C;

    localparam logic TAG_L = 1'b0;
    localparam logic TAG_R = 1'b1;

    typedef struct packed {
        logic [7:0] count;
        logic       tag;
    } fifo_entry_t;

    // Index of the last sample in a 2^N window; N=0 behaves as N=1.
    function automatic logic [6:0] win_last(input logic [2:0] n);
        logic [2:0] ne;
        ne = (n == 3'd0) ? 3'd1 : n;
        return 7'((8'd1 << ne) - 8'd1);
    endfunction

endpackage

// File: rtl/peri_mems_mic_array_if.sv
// rtl/peri_mems_mic_array_if.sv - Wishbone register port of the PDM mic array
interface peri_mems_mic_array_if;

    logic       wb_we_i;
    logic [1:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_stb_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/peri_sync_fifo.sv
// rtl/peri_sync_fifo.sv - single-clock FIFO with registered storage and first-word fall-through head
module peri_sync_fifo #(
    parameter int Width = 9,
    parameter int Depth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     level_o
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o  = (lvl_q == LW'(Depth));
        empty_o = (lvl_q == '0);
        do_pop  = pop_i && !empty_o;
        // A pop frees the slot, so a push while full still lands.
        do_push = push_i && (!full_o || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
        mem_q <= mem_d;
    end

    assign data_o  = mem_q[rd_q];
    assign level_o = lvl_q;

endmodule

// File: rtl/peri_mems_mic_array.sv
// rtl/peri_mems_mic_array.sv - PDM mic array: clock divider, per-channel ones counters, sample FIFO, Wishbone regs
// Build option PERI_MEMS_MIC_IRQ_EN enables THRESH and the level/overflow interrupt.
module peri_mems_mic_array
    import peri_mems_mic_pkg::*;
#(
    parameter int TicksPerHz = 2,
    parameter int Channels   = 2,
    parameter int FifoDepth  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    peri_mems_mic_array_if.slave  wb,
    output logic                  mic_clk_o,
    input  logic                  mic_data_i,
    output logic                  irq_o
);

    localparam int DW = $clog2(TicksPerHz + 1);
    localparam int LW = $clog2(FifoDepth) + 1;

    logic [7:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic          flush_q, flush_d;
    logic [DW-1:0] div_q, div_d;
    logic          mclk_q, mclk_d;
    logic [7:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [6:0]    cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
`ifdef PERI_MEMS_MIC_IRQ_EN
    logic [7:0]    thresh_q, thresh_d;
`endif

    logic          wr_en, rd_en, enable, stereo, tick, fall, rise;
    logic [6:0]    last;
    logic [7:0]    sum_l, sum_r, rdata;
    logic          push, pop, full, empty;
    logic [LW-1:0] level;
    fifo_entry_t   push_data, head;

    always_comb begin
        wr_en  = wb.wb_stb_i && wb.wb_we_i;
        rd_en  = wb.wb_stb_i && !wb.wb_we_i;
        enable = ctrl_q[CTRL_EN_BIT];
        stereo = (Channels == 2) && ctrl_q[CTRL_STEREO_BIT];
        last   = win_last(ctrl_q[CTRL_N_MSB:CTRL_N_LSB]);
        tick   = enable && !flush_q && (div_q == DW'(TicksPerHz - 1));
        // Sampling happens in the cycle before the registered clock edge.
        fall   = tick && mclk_q;
        rise   = tick && !mclk_q && stereo;
        sum_l  = acc_l_q + {7'd0, mic_data_i};
        sum_r  = acc_r_q + {7'd0, mic_data_i};

        ctrl_d  = ctrl_q;
        flush_d = wr_en && (wb.wb_adr_i == ADDR_CTRL);
        if (flush_d) begin
            ctrl_d = wb.wb_dat_i;
            if (Channels == 1) ctrl_d[CTRL_STEREO_BIT] = 1'b0;
        end

        div_d  = div_q;
        mclk_d = mclk_q;
        if (!enable || flush_q) begin
            div_d  = '0;
            mclk_d = 1'b0;
        end else if (tick) begin
            div_d  = '0;
            mclk_d = !mclk_q;
        end else begin
            div_d = div_q + DW'(1);
        end

        acc_l_d   = acc_l_q;
        cnt_l_d   = cnt_l_q;
        acc_r_d   = acc_r_q;
        cnt_r_d   = cnt_r_q;
        push      = 1'b0;
        push_data = '{count: sum_l, tag: TAG_L};
        if (flush_q) begin
            acc_l_d = '0;
            cnt_l_d = '0;
            acc_r_d = '0;
            cnt_r_d = '0;
        end else begin
            if (fall) begin
                if (cnt_l_q == last) begin
                    push    = 1'b1;
                    acc_l_d = '0;
                    cnt_l_d = '0;
                end else begin
                    acc_l_d = sum_l;
                    cnt_l_d = cnt_l_q + 7'd1;
                end
            end
            if (rise) begin
                if (cnt_r_q == last) begin
                    push      = 1'b1;
                    push_data = '{count: sum_r, tag: TAG_R};
                    acc_r_d   = '0;
                    cnt_r_d   = '0;
                end else begin
                    acc_r_d = sum_r;
                    cnt_r_d = cnt_r_q + 7'd1;
                end
            end
        end

        pop   = rd_en && (wb.wb_adr_i == ADDR_DATA) && !empty;
        ovf_d = ovf_q;
        if (wr_en && (wb.wb_adr_i == ADDR_STATUS) && wb.wb_dat_i[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;

`ifdef PERI_MEMS_MIC_IRQ_EN
        thresh_d = thresh_q;
        if (wr_en && (wb.wb_adr_i == ADDR_THRESH)) thresh_d = wb.wb_dat_i;
`endif

        rdata = '0;
        case (wb.wb_adr_i)
            ADDR_DATA:   rdata = empty ? 8'h00 : head.count;
            ADDR_STATUS: begin
                rdata[STAT_OVF_BIT] = ovf_q;
                rdata[STAT_TAG_BIT] = empty ? TAG_L : head.tag;
                rdata[5:0]          = 6'(level);
            end
            ADDR_CTRL:   rdata = ctrl_q;
`ifdef PERI_MEMS_MIC_IRQ_EN
            ADDR_THRESH: rdata = thresh_q;
`else
            ADDR_THRESH: rdata = 8'h00;
`endif
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= CTRL_RESET;
            ovf_q    <= 1'b0;
            flush_q  <= 1'b0;
            div_q    <= '0;
            mclk_q   <= 1'b0;
            acc_l_q  <= '0;
            cnt_l_q  <= '0;
            acc_r_q  <= '0;
            cnt_r_q  <= '0;
`ifdef PERI_MEMS_MIC_IRQ_EN
            thresh_q <= '0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            flush_q  <= flush_d;
            div_q    <= div_d;
            mclk_q   <= mclk_d;
            acc_l_q  <= acc_l_d;
            cnt_l_q  <= cnt_l_d;
            acc_r_q  <= acc_r_d;
            cnt_r_q  <= cnt_r_d;
`ifdef PERI_MEMS_MIC_IRQ_EN
            thresh_q <= thresh_d;
`endif
        end
    end

    peri_sync_fifo #(
        .Width ($bits(fifo_entry_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_q),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign wb.wb_ack_o = wb.wb_stb_i;
    assign wb.wb_dat_o = rdata;
    assign mic_clk_o   = mclk_q;
`ifdef PERI_MEMS_MIC_IRQ_EN
    assign irq_o = ((thresh_q != 8'h00) && (8'(level) >= thresh_q)) || ovf_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_peri_mems_mic_array.sv
// tb/tb_peri_mems_mic_array.sv - scoreboard bench for peri_mems_mic_array (TicksPerHz=2, stereo-capable, depth 16)
module tb_peri_mems_mic_array;
    import peri_mems_mic_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic mic_clk_o, mic_data_i, irq_o;
    logic data_mode = 1'b0;
    logic data_bit  = 1'b0;
    logic last_ack  = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   irq_hi = 0;
    int   t1, t2;
    logic [7:0] d;
    fifo_entry_t exp_q[$];

    peri_mems_mic_array_if bus();

    peri_mems_mic_array #(
        .TicksPerHz (2),
        .Channels   (2),
        .FifoDepth  (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb         (bus.slave),
        .mic_clk_o  (mic_clk_o),
        .mic_data_i (mic_data_i),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (irq_o !== 1'b0) irq_hi <= irq_hi + 1;

    // Stereo pattern: data follows mic_clk, so falls see 1 and rises see 0.
    assign mic_data_i = data_mode ? mic_clk_o : data_bit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat);
        @(negedge clk_i);
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = adr; bus.wb_dat_i = dat;
        @(posedge clk_i); #1;
        bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [7:0] dat);
        @(negedge clk_i);
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = adr;
        #1;
        dat      = bus.wb_dat_o;
        last_ack = bus.wb_ack_o;
        @(posedge clk_i); #1;
        bus.wb_stb_i = 1'b0;
    endtask

    task automatic poll_status(input logic [7:0] mask, input logic [7:0] val,
                               input int budget, input string tag);
        int   n;
        logic hit;
        n = 0; hit = 1'b0;
        @(negedge clk_i);
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = ADDR_STATUS;
        while (!hit && n < budget) begin
            #1;
            if ((bus.wb_dat_o & mask) == val) hit = 1'b1;
            else begin
                @(negedge clk_i);
                n++;
            end
        end
        bus.wb_stb_i = 1'b0;
        check({tag, " reached"}, 32'(hit), 32'(1));
    endtask

    task automatic sb_push(input logic [7:0] count, input logic tag);
        fifo_entry_t e;
        e.count = count;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic drain_one(input string tag);
        fifo_entry_t e;
        logic [7:0]  st, dv;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard has entry"}, 32'(exp_q.size()), 32'(1));
            return;
        end
        e = exp_q.pop_front();
        wb_read(ADDR_STATUS, st);
        check({tag, " head tag"}, 32'(st[STAT_TAG_BIT]), 32'(e.tag));
        wb_read(ADDR_DATA, dv);
        check({tag, " count"}, 32'(dv), 32'(e.count));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_adr_i = 2'd0; bus.wb_dat_i = 8'h00;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b0;

        // Reset state
        check("reset mic_clk", 32'(mic_clk_o), 32'(0));
        check("reset irq", 32'(irq_o), 32'(0));
        wb_read(ADDR_CTRL, d);   check("reset ctrl", 32'(d), 32'h0C);
        check("ack follows stb", 32'(last_ack), 32'(1));
        wb_read(ADDR_STATUS, d); check("reset status", 32'(d), 32'h00);
        wb_read(ADDR_THRESH, d); check("reset thresh", 32'(d), 32'h00);
        wb_read(ADDR_DATA, d);   check("reset empty data", 32'(d), 32'h00);
        wb_read(ADDR_STATUS, d); check("reset level after empty read", 32'(d), 32'h00);

        // Mono, all ones, N=3: 8 samples per window, one push per 32 clk_i cycles
        data_bit = 1'b1;
        wb_write(ADDR_CTRL, 8'h07);
        wb_read(ADDR_CTRL, d); check("ctrl readback mono", 32'(d), 32'h07);
        sb_push(8'h08, TAG_L);
        sb_push(8'h08, TAG_L);
        poll_status(8'h3F, 8'h01, 200, "mono level 1"); t1 = cyc;
        poll_status(8'h3F, 8'h02, 200, "mono level 2"); t2 = cyc;
        check("mono push interval", 32'(t2 - t1), 32'(32));
        drain_one("mono 0");
        drain_one("mono 1");

        // Stereo: right window completes first (first mic_clk edge is a rise)
        data_mode = 1'b1;
        wb_write(ADDR_CTRL, 8'h17);
        wb_read(ADDR_CTRL, d); check("ctrl readback stereo", 32'(d), 32'h17);
        sb_push(8'h00, TAG_R);
        sb_push(8'h08, TAG_L);
        sb_push(8'h00, TAG_R);
        sb_push(8'h08, TAG_L);
        poll_status(8'h3F, 8'h04, 300, "stereo level 4");
        for (int i = 0; i < 4; i++) drain_one($sformatf("stereo %0d", i));

        // Fill to 16, then overflow on the 17th push
        data_mode = 1'b0;
        data_bit  = 1'b1;
        wb_write(ADDR_CTRL, 8'h07);
        poll_status(8'h3F, 8'h10, 800, "fill level 16");
        wb_read(ADDR_STATUS, d); check("full status", 32'(d), 32'h10);
        poll_status(8'h80, 8'h80, 100, "overflow set");
        wb_read(ADDR_STATUS, d); check("overflow status", 32'(d), 32'h90);
        wb_write(ADDR_STATUS, 8'h80);
        wb_read(ADDR_STATUS, d); check("overflow cleared", 32'(d), 32'h10);

        // Pop in the exact cycle of the next push while full
        poll_status(8'h80, 8'h80, 100, "overflow set again");
        wb_write(ADDR_STATUS, 8'h80);
        repeat (29) @(negedge clk_i);
        wb_read(ADDR_DATA, d);   check("pop with push data", 32'(d), 32'h08);
        wb_read(ADDR_STATUS, d); check("pop with push status", 32'(d), 32'h10);

        // CTRL write flushes; mid-window rewrite discards partial window
        wb_write(ADDR_CTRL, 8'h07);
        @(posedge clk_i);
        wb_read(ADDR_STATUS, d); check("flush status", 32'(d), 32'h00);
        wb_read(ADDR_DATA, d);   check("empty data read", 32'(d), 32'h00);
        wb_read(ADDR_STATUS, d); check("empty read keeps level", 32'(d), 32'h00);
        repeat (12) @(posedge clk_i);
        wb_write(ADDR_CTRL, 8'h07);
        sb_push(8'h08, TAG_L);
        poll_status(8'h3F, 8'h01, 100, "post-rewrite push");
        drain_one("post-rewrite");

`ifdef PERI_MEMS_MIC_IRQ_EN
        wb_write(ADDR_THRESH, 8'h04);
        wb_read(ADDR_THRESH, d); check("thresh readback", 32'(d), 32'h04);
        wb_write(ADDR_CTRL, 8'h07);
        poll_status(8'h3F, 8'h03, 200, "irq level 3");
        check("irq low at level 3", 32'(irq_o), 32'(0));
        poll_status(8'h3F, 8'h04, 100, "irq level 4");
        check("irq high at level 4", 32'(irq_o), 32'(1));
        wb_read(ADDR_DATA, d);
        check("irq low after pop", 32'(irq_o), 32'(0));
        wb_read(ADDR_STATUS, d); check("level after irq pop", 32'(d), 32'h03);
`else
        wb_write(ADDR_THRESH, 8'h04);
        wb_read(ADDR_THRESH, d); check("thresh ignored", 32'(d), 32'h00);
`endif

        // Reset in the middle of a window
        wb_write(ADDR_CTRL, 8'h07);
        repeat (12) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b0;
        wb_read(ADDR_CTRL, d);   check("mid reset ctrl", 32'(d), 32'h0C);
        wb_read(ADDR_STATUS, d); check("mid reset status", 32'(d), 32'h00);
        repeat (20) @(negedge clk_i);
        check("disabled mic_clk", 32'(mic_clk_o), 32'(0));

`ifndef PERI_MEMS_MIC_IRQ_EN
        check("irq never high", 32'(irq_hi), 32'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peri_mems_mic_array.md
PERI_MEMS_MIC_ARRAY -- requirements
Module: peri_mems_mic_array

Interface
REQ-001 SHALL have parameter TicksPerHz, default 2: clk_i cycles per mic_clk_o half-period (>=1).
REQ-002 SHALL have parameter Channels, default 2: PDM channels, 1 or 2.
REQ-003 SHALL have parameter FifoDepth, default 16: sample FIFO entries, power of 2, 2..32.
REQ-004 SHALL have port clk_i  input  1  sole clock.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports wb_we_i input 1, wb_adr_i input 2, wb_dat_i input 8, wb_stb_i input 1: Wishbone B4 peripheral request.
REQ-007 SHALL have ports wb_dat_o output 8, wb_ack_o output 1: Wishbone response.
REQ-008 SHALL have ports mic_clk_o output 1 (PDM clock) and mic_data_i input 1 (shared PDM data line).
REQ-009 SHALL have port irq_o  output  1  interrupt request, level.

Function
REQ-010 SHALL drive wb_ack_o = wb_stb_i combinationally; every access completes in its request cycle.
REQ-011 SHALL decode registers: 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH.
REQ-012 CTRL SHALL hold: bit0 enable; bits3:1 window exponent N; bit4 stereo (forced 0 when Channels==1). N=0 is treated as N=1.
REQ-013 Any CTRL write SHALL flush the FIFO, clear the divider, and clear all accumulators and window counters in the following cycle.
REQ-014 While enable=0, mic_clk_o SHALL stay 0 and no samples SHALL be taken.
REQ-015 While enabled, mic_clk_o SHALL toggle every TicksPerHz clk_i cycles, starting low.
REQ-016 Left channel SHALL sample mic_data_i in the clk_i cycle where mic_clk_o goes 1->0; right channel (stereo=1) SHALL sample where it goes 0->1.
REQ-017 Each channel SHALL count ones over 2^N of its own samples, then push the 8-bit count. The window's last sample SHALL be included, and the next window SHALL start from zero.
REQ-018 Pushes SHALL be single-ported: at most one per cycle. Left and right windows end on opposite edges, so entries interleave L,R.
REQ-019 Each FIFO entry SHALL store the count plus a 1-bit channel tag (0=L, 1=R).
REQ-020 A DATA read SHALL return the head count combinationally and pop it in the same cycle. On an empty FIFO it SHALL return 0x00 and not pop. DATA writes SHALL be ignored.
REQ-021 STATUS read SHALL return {overflow, head tag, level[5:0]}, where head tag is 0 when empty.
REQ-022 A STATUS write with bit7=1 SHALL clear overflow. Other STATUS bits are not writable.
REQ-023 A push while full with no pop in that cycle SHALL drop the new sample and set overflow. A simultaneous push and pop while full SHALL do both, with no overflow.
REQ-024 A push into an empty FIFO SHALL be readable on the next cycle.
REQ-025 CTRL and THRESH SHALL read back their stored values.

Reset
REQ-026 On rst_i: CTRL=0x0C (disabled, N=6, mono), THRESH=0, FIFO empty, overflow=0, divider and accumulators cleared.
REQ-027 After rst_i: mic_clk_o=0, irq_o=0, wb_dat_o reflects the reset register values.
REQ-028 rst_i asserted mid-window SHALL discard the partial window.

Configuration
REQ-029 With PERI_MEMS_MIC_IRQ_EN defined: irq_o = (THRESH!=0) && (level>=THRESH) || overflow.
REQ-030 Without PERI_MEMS_MIC_IRQ_EN: irq_o tied 0, THRESH writes ignored, THRESH reads 0x00.

Structure
REQ-031 Package peri_mems_mic_pkg SHALL hold register address constants, CTRL/STATUS bit positions, and the FIFO entry struct (count, tag).
REQ-032 The FIFO SHALL be sub-module peri_sync_fifo (parameters Width, Depth). It SHALL have push/pop/full/empty/level and registered storage.

Verification
REQ-033 TicksPerHz=2, write CTRL=0x07 (enable, N=3, mono), mic_data_i=1 -> push every 32 clk_i cycles; DATA reads 0x08, tag 0.
REQ-034 CTRL=0x17 (stereo, N=3), mic_data_i=1 on falling-edge samples and 0 on rising-edge samples -> FIFO holds 0x08(L), 0x00(R) alternating; STATUS bit6 toggles after each pop.
REQ-035 Fill FifoDepth=16 without reads -> level=16; next push sets STATUS=0x90 with head tag L; write STATUS 0x80 -> overflow clears.
REQ-036 FIFO full and a DATA read in the same cycle as a push -> level stays 16, overflow stays 0.
REQ-037 Read DATA on an empty FIFO -> 0x00, level stays 0. A CTRL write mid-window -> FIFO empty, first new push counts only post-write samples.
REQ-038 IRQ_EN build, THRESH=4 -> irq_o rises in the cycle level reaches 4 and falls when a pop brings level to 3. Non-IRQ_EN build -> irq_o constantly 0.
